// File: rtl/uart_pkg.sv
// Shared UART definitions.
// Arbiter state encoding and the frame width shared with the transmitter.
package uart_pkg;

    localparam int UART_FRAME_BITS = 8;

    typedef enum logic [1:0] {
        ARB       = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority picker.
// Picks the first eligible index at or above ptr_i, wrapping around.
module rr_pick #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] elig_i,
    input  logic [W-1:0] ptr_i,
    output logic [N-1:0] gnt_o,
    output logic         valid_o
);

    logic [W-1:0] idx;

    // Walk N slots from the pointer; the first eligible slot wins.
    always_comb begin
        gnt_o   = '0;
        valid_o = 1'b0;
        idx     = ptr_i;
        for (int k = 0; k < N; k++) begin
            if (!valid_o && elig_i[idx]) begin
                gnt_o[idx] = 1'b1;
                valid_o    = 1'b1;
            end
            idx = (idx == W'(N - 1)) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between byte sources.
// Multi-byte packets keep the owner locked until the last byte is sent.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int FRAME_BITS   = UART_FRAME_BITS,
    parameter int BUSY_TIMEOUT = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*FRAME_BITS-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ack,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          tx_start,
    output logic [FRAME_BITS-1:0]         tx_data,
    input  logic                          tx_status,
    output logic                          busy,
    output logic                          timeout_err
);

    localparam int OW = $clog2(NUM_REQ);
    localparam int CW = $clog2(BUSY_TIMEOUT + 1);

    arb_state_e            state_q, state_d;
    logic [OW-1:0]         rr_q, rr_d;
    logic [OW-1:0]         owner_q, owner_d;
    logic                  locked_q, locked_d;
    logic                  last_q, last_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [FRAME_BITS-1:0] data_q, data_d;
    logic [NUM_REQ-1:0]    grant_q, grant_d;

    logic [NUM_REQ-1:0]    elig;
    logic [NUM_REQ-1:0]    pick_oh;
    logic                  pick_vld;
    logic [OW-1:0]         win_idx;
    logic [FRAME_BITS-1:0] win_data;
    logic                  win_last;
    logic [OW-1:0]         rr_nxt;

    // A locked packet owner is the only requester allowed to compete.
    assign elig = locked_q ? (req & grant_q) : req;

    assign rr_nxt = (owner_q == OW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

    rr_pick #(
        .N(NUM_REQ),
        .W(OW)
    ) u_pick (
        .elig_i (elig),
        .ptr_i  (rr_q),
        .gnt_o  (pick_oh),
        .valid_o(pick_vld)
    );

    // Fold the one-hot winner into an index plus its byte and last flag.
    always_comb begin
        win_idx  = '0;
        win_data = '0;
        win_last = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_oh[i]) begin
                win_idx  = OW'(i);
                win_data = req_data[i*FRAME_BITS +: FRAME_BITS];
                win_last = req_last[i];
            end
        end
    end

    // Next-state and pulse outputs of the arbitration FSM.
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        owner_d     = owner_q;
        locked_d    = locked_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        grant_d     = grant_q;
        tx_start    = 1'b0;
        req_ack     = '0;
        timeout_err = 1'b0;
        unique case (state_q)
            ARB: begin
                if (pick_vld) begin
                    owner_d = win_idx;
                    grant_d = pick_oh;
                    data_d  = win_data;
                    last_d  = win_last;
                    state_d = LAUNCH;
                end else if (!locked_q) begin
                    grant_d = '0;
                end
            end
            LAUNCH: begin
                tx_start = 1'b1;
                req_ack  = grant_q;
                cnt_d    = '0;
                state_d  = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_status) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == CW'(BUSY_TIMEOUT - 1)) begin
                    timeout_err = 1'b1;
                    locked_d    = 1'b0;
                    rr_d        = rr_nxt;
                    grant_d     = '0;
                    state_d     = ARB;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!tx_status) begin
                    state_d = ARB;
                    if (last_q) begin
                        locked_d = 1'b0;
                        rr_d     = rr_nxt;
                        grant_d  = '0;
                    end else begin
                        locked_d = 1'b1;
                    end
                end
            end
            default: state_d = ARB;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ARB;
            rr_q     <= '0;
            owner_q  <= '0;
            locked_q <= 1'b0;
            last_q   <= 1'b0;
            cnt_q    <= '0;
            data_q   <= '0;
            grant_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            owner_q  <= owner_d;
            locked_q <= locked_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            grant_q  <= grant_d;
        end
    end

    assign tx_data = data_q;
    assign grant   = grant_q;
    assign busy    = (state_q != ARB);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter.
// A small transmitter model answers tx_start with a 4-cycle busy frame.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int FB = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  req;
    logic [N-1:0]  req_last;
    logic [N*FB-1:0] req_data;
    logic [N-1:0]  req_ack;
    logic [N-1:0]  grant;
    logic          tx_start;
    logic [FB-1:0] tx_data;
    logic          tx_status;
    logic          busy;
    logic          timeout_err;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int fall_cyc = 0;
    int moved = 0;
    bit tx_en = 1'b1;

    uart_tx_arbiter #(
        .NUM_REQ(N),
        .FRAME_BITS(FB),
        .BUSY_TIMEOUT(8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_last   (req_last),
        .req_data   (req_data),
        .req_ack    (req_ack),
        .grant      (grant),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_status  (tx_status),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter model: busy for 4 cycles after each start pulse.
    initial begin
        int mcnt;
        logic [FB-1:0] held;
        mcnt = 0;
        held = '0;
        tx_status = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (!reset) begin
                tx_status = 1'b0;
                mcnt = 0;
            end else if (mcnt > 0) begin
                if (tx_status && tx_data != held) moved++;
                mcnt--;
                if (mcnt == 0) begin
                    tx_status = 1'b0;
                    fall_cyc = cyc;
                end
            end else if (tx_en && tx_start) begin
                tx_status = 1'b1;
                held = tx_data;
                mcnt = 4;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_byte(input int i, input logic [FB-1:0] v);
        req_data[i*FB +: FB] = v;
    endtask

    task automatic wait_start();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (tx_start) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk("start_seen", 32'(ok), 1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk("idle_seen", 32'(ok), 1);
    endtask

    initial begin
        int n;
        int starts;
        logic [N-1:0] exp_oh;
        reset = 1'b0;
        req = '0;
        req_last = '0;
        req_data = '0;
        repeat (3) tick();

        // Reset state
        chk("rst_grant", 32'(grant), 0);
        chk("rst_start", 32'(tx_start), 0);
        chk("rst_ack", 32'(req_ack), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_data", 32'(tx_data), 0);
        chk("rst_to", 32'(timeout_err), 0);
        reset = 1'b1;
        tick();

        // Round robin from pointer 0: 0,1,2,3,0
        for (int i = 0; i < N; i++) set_byte(i, 8'hC0 + 8'(i));
        req = 4'b1111;
        req_last = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_oh = 4'b0001 << (k % N);
            wait_start();
            chk("rr_grant", 32'(grant), 32'(exp_oh));
            chk("rr_ack", 32'(req_ack), 32'(exp_oh));
            chk("rr_data", 32'(tx_data), 32'(8'hC0 + 8'(k % N)));
            if (k == 4) req = '0;
            tick();
            chk("rr_ack_once", 32'(req_ack), 0);
        end
        wait_idle();

        // Single byte: start one cycle after req is sampled
        set_byte(1, 8'hA5);
        req = 4'b0010;
        req_last = 4'b0010;
        tick();
        chk("one_start", 32'(tx_start), 1);
        chk("one_ack", 32'(req_ack), 32'(4'b0010));
        chk("one_data", 32'(tx_data), 32'h A5);
        chk("one_grant", 32'(grant), 32'(4'b0010));
        req = '0;
        tick();
        chk("one_ack_off", 32'(req_ack), 0);
        wait_idle();
        chk("one_grant_end", 32'(grant), 0);

        // Packet lock: requester 2 sends 3 bytes while 0 waits
        set_byte(0, 8'h0F);
        set_byte(2, 8'hB0);
        req_last = 4'b0001;
        req = 4'b0101;
        wait_start();
        chk("lk_grant0", 32'(grant), 32'(4'b0100));
        chk("lk_data0", 32'(tx_data), 32'h B0);
        tick();
        req = 4'b0001;
        wait_idle();
        starts = 0;
        for (int i = 0; i < 20; i++) begin
            if (tx_start) starts++;
            tick();
        end
        chk("lk_hold_starts", 32'(starts), 0);
        chk("lk_hold_grant", 32'(grant), 32'(4'b0100));
        set_byte(2, 8'hB1);
        req = 4'b0101;
        wait_start();
        chk("lk_grant1", 32'(grant), 32'(4'b0100));
        chk("lk_data1", 32'(tx_data), 32'h B1);
        tick();
        set_byte(2, 8'hB2);
        req_last = 4'b0101;
        wait_start();
        chk("lk_grant2", 32'(grant), 32'(4'b0100));
        chk("lk_data2", 32'(tx_data), 32'h B2);
        tick();
        req = 4'b0001;
        wait_start();
        chk("lk_next_grant", 32'(grant), 32'(4'b0001));
        chk("lk_next_data", 32'(tx_data), 32'h 0F);
        tick();
        req = '0;
        wait_idle();

        // Back-to-back bytes of one packet from requester 3
        moved = 0;
        set_byte(3, 8'hD0);
        req_last = 4'b0000;
        req = 4'b1000;
        wait_start();
        chk("b2b_data0", 32'(tx_data), 32'h D0);
        tick();
        set_byte(3, 8'hD1);
        wait_start();
        chk("b2b_gap1", 32'(cyc - fall_cyc), 2);
        chk("b2b_data1", 32'(tx_data), 32'h D1);
        tick();
        set_byte(3, 8'hD2);
        req_last = 4'b1000;
        wait_start();
        chk("b2b_gap2", 32'(cyc - fall_cyc), 2);
        chk("b2b_data2", 32'(tx_data), 32'h D2);
        tick();
        req = '0;
        wait_idle();
        chk("b2b_stable", 32'(moved), 0);

        // Timeout: transmitter never goes busy
        tx_en = 1'b0;
        set_byte(1, 8'h77);
        req_last = 4'b0000;
        req = 4'b0010;
        wait_start();
        chk("to_grant", 32'(grant), 32'(4'b0010));
        req = '0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n++;
            if (timeout_err) break;
        end
        chk("to_latency", 32'(n), 8);
        tx_en = 1'b1;
        set_byte(0, 8'h5A);
        req_last = 4'b0001;
        req = 4'b0001;
        tick();
        chk("to_arb", 32'(busy), 0);
        chk("to_pulse_off", 32'(timeout_err), 0);
        chk("to_grant_clr", 32'(grant), 0);
        wait_start();
        chk("to_unlock", 32'(grant), 32'(4'b0001));
        chk("to_data", 32'(tx_data), 32'h 5A);
        tick();
        req = '0;
        wait_idle();

        // Reset during WAIT_DONE of a locked packet
        set_byte(3, 8'hE0);
        req_last = 4'b0000;
        req = 4'b1000;
        wait_start();
        tick();
        req = '0;
        tick();
        tick();
        chk("mr_inframe", 32'(busy), 1);
        reset = 1'b0;
        tick();
        chk("mr_grant", 32'(grant), 0);
        chk("mr_busy", 32'(busy), 0);
        chk("mr_data", 32'(tx_data), 0);
        chk("mr_start", 32'(tx_start), 0);
        chk("mr_ack", 32'(req_ack), 0);
        reset = 1'b1;
        for (int i = 0; i < N; i++) set_byte(i, 8'h90 + 8'(i));
        req_last = 4'b1111;
        req = 4'b1111;
        wait_start();
        chk("mr_grant0", 32'(grant), 32'(4'b0001));
        chk("mr_data0", 32'(tx_data), 32'h 90);
        tick();
        req = '0;
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
